// File: rtl/stamofu_req_tlb_stage_pkg.sv
// Shared core types for the stamofu REQ/dTLB stage.
// Holds the address/index widths, the buffered request entry type,
// the RISC-V store exception cause codes and the stage FSM encoding.
package core_types_pkg;

    localparam int VPN_WIDTH              = 20;
    localparam int PPN_WIDTH              = 22;
    localparam int PO_WIDTH               = 12;
    localparam int LOG_STAMOFU_CQ_ENTRIES = 3;

    localparam logic [3:0] STORE_MISALIGNED   = 4'd6;
    localparam logic [3:0] STORE_ACCESS_FAULT = 4'd7;
    localparam logic [3:0] STORE_PAGE_FAULT   = 4'd15;

    typedef struct packed {
        logic                              is_mq;
        logic                              misaligned;
        logic                              misaligned_exception;
        logic [VPN_WIDTH-1:0]              VPN;
        logic [PO_WIDTH-3:0]               PO_word;
        logic [3:0]                        byte_mask;
        logic [31:0]                       write_data;
        logic [LOG_STAMOFU_CQ_ENTRIES-1:0] cq_index;
    } stamofu_req_entry_t;

    typedef enum logic [1:0] {
        S_IDLE,
        S_TLB_REQ,
        S_TLB_WAIT,
        S_UPDATE
    } stamofu_tlb_state_t;

endpackage

// File: rtl/stamofu_req_tlb_stage_fifo.sv
// stamofu_req_fifo: small circular buffer of stamofu request entries.
// Ports:
//   i_clk, i_rst      clock, async active-high reset (pointers/count only)
//   i_push, i_entry   enqueue (ignored when full)
//   i_pop             dequeue (ignored when empty)
//   o_head, o_next    entry at head and the one behind it
//   o_full, o_empty   status from the registered count
//   o_count           number of valid entries
module stamofu_req_fifo
    import core_types_pkg::*;
#(
    parameter int DEPTH     = 2,
    parameter int LOG_DEPTH = $clog2(DEPTH)
) (
    input  logic                 i_clk,
    input  logic                 i_rst,
    input  logic                 i_push,
    input  stamofu_req_entry_t   i_entry,
    input  logic                 i_pop,
    output stamofu_req_entry_t   o_head,
    output stamofu_req_entry_t   o_next,
    output logic                 o_full,
    output logic                 o_empty,
    output logic [LOG_DEPTH:0]   o_count
);

    stamofu_req_entry_t     r_mem [DEPTH];
    logic [LOG_DEPTH-1:0]   r_head;
    logic [LOG_DEPTH-1:0]   r_tail;
    logic [LOG_DEPTH:0]     r_count;
    logic [LOG_DEPTH-1:0]   w_next_ptr;
    logic                   w_push;
    logic                   w_pop;

    assign o_full     = (r_count == (LOG_DEPTH+1)'(DEPTH));
    assign o_empty    = (r_count == '0);
    assign o_count    = r_count;
    assign w_push     = i_push & ~o_full;
    assign w_pop      = i_pop & ~o_empty;
    // Power-of-2 depth: pointers wrap by natural overflow.
    assign w_next_ptr = r_head + 1'b1;
    assign o_head     = r_mem[r_head];
    assign o_next     = r_mem[w_next_ptr];

    // Payload storage needs no reset; validity lives in r_count.
    always_ff @(posedge i_clk) begin
        if (w_push) r_mem[r_tail] <= i_entry;
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
        end else begin
            if (w_push) r_tail <= r_tail + 1'b1;
            if (w_pop)  r_head <= w_next_ptr;
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/stamofu_req_tlb_stage.sv
// stamofu_req_tlb_stage: consumer of the stamofu REQ interface.
// Buffers store/AMO/fence requests and translates the head entry through
// the dTLB, one at a time, then reports PA or exception to the CQ or MQ.
// Ports:
//   CLK, RST                 clock, async active-high reset
//   REQ_*                    incoming request, REQ_ack = buffer not full
//   dtlb_req_*               translation request (valid/ready, VPN)
//   dtlb_resp_*              translation result (PPN, page/access fault)
//   update_*                 result to CQ/MQ (valid/ready, held while stalled)
module stamofu_req_tlb_stage
    import core_types_pkg::*;
#(
    parameter int FIFO_DEPTH     = 2,
    parameter int LOG_FIFO_DEPTH = $clog2(FIFO_DEPTH)
) (
    input  logic                              CLK,
    input  logic                              RST,

    input  logic                              REQ_valid,
    input  logic                              REQ_is_mq,
    input  logic                              REQ_misaligned,
    input  logic                              REQ_misaligned_exception,
    input  logic [VPN_WIDTH-1:0]              REQ_VPN,
    input  logic [PO_WIDTH-3:0]               REQ_PO_word,
    input  logic [3:0]                        REQ_byte_mask,
    input  logic [31:0]                       REQ_write_data,
    input  logic [LOG_STAMOFU_CQ_ENTRIES-1:0] REQ_cq_index,
    output logic                              REQ_ack,

    output logic                              dtlb_req_valid,
    output logic [VPN_WIDTH-1:0]              dtlb_req_VPN,
    input  logic                              dtlb_req_ready,

    input  logic                              dtlb_resp_valid,
    input  logic [PPN_WIDTH-1:0]              dtlb_resp_PPN,
    input  logic                              dtlb_resp_page_fault,
    input  logic                              dtlb_resp_access_fault,

    output logic                              update_valid,
    output logic                              update_is_mq,
    output logic [LOG_STAMOFU_CQ_ENTRIES-1:0] update_cq_index,
    output logic [PPN_WIDTH-1:0]              update_PPN,
    output logic [PO_WIDTH-3:0]               update_PO_word,
    output logic [3:0]                        update_byte_mask,
    output logic                              update_misaligned,
    output logic [31:0]                       update_write_data,
    output logic                              update_exception,
    output logic [3:0]                        update_exception_code,
    input  logic                              update_ready
);

    stamofu_tlb_state_t         r_state;
    stamofu_tlb_state_t         w_state_nxt;

    stamofu_req_entry_t         w_req_entry;
    stamofu_req_entry_t         w_head;
    stamofu_req_entry_t         w_next;
    logic                       w_full;
    logic                       w_empty;
    logic [LOG_FIFO_DEPTH:0]    w_count;
    logic                       w_push;
    logic                       w_pop;

    logic                       w_dtlb_req;
    logic                       w_upd;
    logic                       w_ld_misalign;
    logic                       w_ld_resp;

    logic [PPN_WIDTH-1:0]       r_res_ppn;
    logic                       r_res_exc;
    logic [3:0]                 r_res_code;

    // ---------------- request buffer ----------------
    assign w_req_entry = '{
        is_mq:                REQ_is_mq,
        misaligned:           REQ_misaligned,
        misaligned_exception: REQ_misaligned_exception,
        VPN:                  REQ_VPN,
        PO_word:              REQ_PO_word,
        byte_mask:            REQ_byte_mask,
        write_data:           REQ_write_data,
        cq_index:             REQ_cq_index
    };

    // Ack comes only from the registered count, so a full buffer never
    // accepts even when the head pops in the same cycle.
    assign REQ_ack = ~w_full;
    assign w_push  = REQ_valid & REQ_ack;

    stamofu_req_fifo #(
        .DEPTH     (FIFO_DEPTH),
        .LOG_DEPTH (LOG_FIFO_DEPTH)
    ) u_fifo (
        .i_clk   (CLK),
        .i_rst   (RST),
        .i_push  (w_push),
        .i_entry (w_req_entry),
        .i_pop   (w_pop),
        .o_head  (w_head),
        .o_next  (w_next),
        .o_full  (w_full),
        .o_empty (w_empty),
        .o_count (w_count)
    );

    // ---------------- FSM ----------------
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) r_state <= S_IDLE;
        else     r_state <= w_state_nxt;
    end

    // IDLE with a non-exception head issues the dTLB request directly, so a
    // request enqueued into an empty buffer is presented to the dTLB on the
    // following cycle. TLB_REQ is the holding state when the dTLB stalls or
    // when the next entry is picked up straight out of UPDATE.
    always_comb begin
        w_state_nxt   = r_state;
        w_dtlb_req    = 1'b0;
        w_pop         = 1'b0;
        w_ld_misalign = 1'b0;
        w_ld_resp     = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (!w_empty) begin
                    if (w_head.misaligned_exception) begin
                        w_ld_misalign = 1'b1;
                        w_state_nxt   = S_UPDATE;
                    end else begin
                        w_dtlb_req  = 1'b1;
                        w_state_nxt = dtlb_req_ready ? S_TLB_WAIT : S_TLB_REQ;
                    end
                end
            end
            S_TLB_REQ: begin
                w_dtlb_req = 1'b1;
                if (dtlb_req_ready) w_state_nxt = S_TLB_WAIT;
            end
            S_TLB_WAIT: begin
                if (dtlb_resp_valid) begin
                    w_ld_resp   = 1'b1;
                    w_state_nxt = S_UPDATE;
                end
            end
            S_UPDATE: begin
                if (update_ready) begin
                    w_pop = 1'b1;
                    // Look past the popping head; a same-cycle push is not
                    // visible yet and will be picked up from IDLE.
                    if (w_count > (LOG_FIFO_DEPTH+1)'(1)) begin
                        if (w_next.misaligned_exception) begin
                            w_ld_misalign = 1'b1;
                            w_state_nxt   = S_UPDATE;
                        end else begin
                            w_state_nxt   = S_TLB_REQ;
                        end
                    end else begin
                        w_state_nxt = S_IDLE;
                    end
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // ---------------- head result ----------------
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_res_ppn  <= '0;
            r_res_exc  <= 1'b0;
            r_res_code <= '0;
        end else if (w_ld_misalign) begin
            r_res_ppn  <= '0;
            r_res_exc  <= 1'b1;
            r_res_code <= STORE_MISALIGNED;
        end else if (w_ld_resp) begin
            // Page fault outranks access fault when both are reported.
            if (dtlb_resp_page_fault) begin
                r_res_ppn  <= '0;
                r_res_exc  <= 1'b1;
                r_res_code <= STORE_PAGE_FAULT;
            end else if (dtlb_resp_access_fault) begin
                r_res_ppn  <= '0;
                r_res_exc  <= 1'b1;
                r_res_code <= STORE_ACCESS_FAULT;
            end else begin
                r_res_ppn  <= dtlb_resp_PPN;
                r_res_exc  <= 1'b0;
                r_res_code <= '0;
            end
        end
    end

    // ---------------- outputs ----------------
    // Data outputs are gated by state so they read zero whenever the
    // handshake is idle, including the cycle RST rises.
    assign w_upd = (r_state == S_UPDATE);

    assign dtlb_req_valid        = w_dtlb_req;
    assign dtlb_req_VPN          = w_dtlb_req ? w_head.VPN : '0;

    assign update_valid          = w_upd;
    assign update_is_mq          = w_upd ? w_head.is_mq      : 1'b0;
    assign update_cq_index       = w_upd ? w_head.cq_index   : '0;
    assign update_PPN            = w_upd ? r_res_ppn         : '0;
    assign update_PO_word        = w_upd ? w_head.PO_word    : '0;
    assign update_byte_mask      = w_upd ? w_head.byte_mask  : '0;
    assign update_misaligned     = w_upd ? w_head.misaligned : 1'b0;
    assign update_write_data     = w_upd ? w_head.write_data : '0;
    assign update_exception      = w_upd ? r_res_exc         : 1'b0;
    assign update_exception_code = w_upd ? r_res_code        : '0;

endmodule

// File: tb/tb_stamofu_req_tlb_stage.sv
module tb_stamofu_req_tlb_stage;
    import core_types_pkg::*;

    logic                              CLK = 1'b0;
    logic                              RST;
    logic                              REQ_valid, REQ_is_mq, REQ_misaligned, REQ_misaligned_exception;
    logic [VPN_WIDTH-1:0]              REQ_VPN;
    logic [PO_WIDTH-3:0]               REQ_PO_word;
    logic [3:0]                        REQ_byte_mask;
    logic [31:0]                       REQ_write_data;
    logic [LOG_STAMOFU_CQ_ENTRIES-1:0] REQ_cq_index;
    logic                              REQ_ack;
    logic                              dtlb_req_valid, dtlb_req_ready;
    logic [VPN_WIDTH-1:0]              dtlb_req_VPN;
    logic                              dtlb_resp_valid, dtlb_resp_page_fault, dtlb_resp_access_fault;
    logic [PPN_WIDTH-1:0]              dtlb_resp_PPN;
    logic                              update_valid, update_is_mq, update_misaligned, update_exception;
    logic [LOG_STAMOFU_CQ_ENTRIES-1:0] update_cq_index;
    logic [PPN_WIDTH-1:0]              update_PPN;
    logic [PO_WIDTH-3:0]               update_PO_word;
    logic [3:0]                        update_byte_mask, update_exception_code;
    logic [31:0]                       update_write_data;
    logic                              update_ready;

    stamofu_req_tlb_stage #(.FIFO_DEPTH(2)) dut (
        .CLK(CLK), .RST(RST),
        .REQ_valid(REQ_valid), .REQ_is_mq(REQ_is_mq), .REQ_misaligned(REQ_misaligned),
        .REQ_misaligned_exception(REQ_misaligned_exception), .REQ_VPN(REQ_VPN),
        .REQ_PO_word(REQ_PO_word), .REQ_byte_mask(REQ_byte_mask),
        .REQ_write_data(REQ_write_data), .REQ_cq_index(REQ_cq_index), .REQ_ack(REQ_ack),
        .dtlb_req_valid(dtlb_req_valid), .dtlb_req_VPN(dtlb_req_VPN), .dtlb_req_ready(dtlb_req_ready),
        .dtlb_resp_valid(dtlb_resp_valid), .dtlb_resp_PPN(dtlb_resp_PPN),
        .dtlb_resp_page_fault(dtlb_resp_page_fault), .dtlb_resp_access_fault(dtlb_resp_access_fault),
        .update_valid(update_valid), .update_is_mq(update_is_mq), .update_cq_index(update_cq_index),
        .update_PPN(update_PPN), .update_PO_word(update_PO_word), .update_byte_mask(update_byte_mask),
        .update_misaligned(update_misaligned), .update_write_data(update_write_data),
        .update_exception(update_exception), .update_exception_code(update_exception_code),
        .update_ready(update_ready)
    );

    always #5 CLK = ~CLK;

    int n_chk = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic clr_in();
        REQ_valid = 0; REQ_is_mq = 0; REQ_misaligned = 0; REQ_misaligned_exception = 0;
        REQ_VPN = '0; REQ_PO_word = '0; REQ_byte_mask = '0; REQ_write_data = '0; REQ_cq_index = '0;
        dtlb_req_ready = 0; dtlb_resp_valid = 0; dtlb_resp_PPN = '0;
        dtlb_resp_page_fault = 0; dtlb_resp_access_fault = 0; update_ready = 0;
    endtask

    task automatic drive_req(input stamofu_req_entry_t e);
        REQ_valid = 1; REQ_is_mq = e.is_mq; REQ_misaligned = e.misaligned;
        REQ_misaligned_exception = e.misaligned_exception; REQ_VPN = e.VPN;
        REQ_PO_word = e.PO_word; REQ_byte_mask = e.byte_mask;
        REQ_write_data = e.write_data; REQ_cq_index = e.cq_index;
    endtask

    task automatic step(); @(posedge CLK); #1; endtask
    task automatic samp(); @(negedge CLK); endtask

    function automatic stamofu_req_entry_t mk(input logic mq, input logic mx, input logic [19:0] vpn,
                                              input logic [9:0] po, input logic [31:0] d, input logic [2:0] idx);
        stamofu_req_entry_t e;
        e.is_mq = mq; e.misaligned = mx; e.misaligned_exception = mx; e.VPN = vpn;
        e.PO_word = po; e.byte_mask = 4'b1111; e.write_data = d; e.cq_index = idx;
        return e;
    endfunction

    // reference-model state for the random phase
    stamofu_req_entry_t q[$];
    stamofu_req_entry_t e, r;
    bit                 pend, have_x, held;
    int                 dly, n_upd;
    logic [21:0]        x_ppn;
    logic               x_exc;
    logic [3:0]         x_code;
    logic [63:0]        snap, cur;
    int                 n_acc;
    int                 order[$];

    initial begin
        clr_in();
        RST = 1;

        // ---- reset state ----
        samp();
        chk("rst_ack", REQ_ack, 1);
        chk("rst_dtlb_v", dtlb_req_valid, 0);
        chk("rst_upd_v", update_valid, 0);
        chk("rst_data", {dtlb_req_VPN, update_PPN, update_write_data}, 0);
        chk("rst_data2", {update_cq_index, update_PO_word, update_byte_mask, update_exception_code,
                          update_is_mq, update_misaligned, update_exception}, 0);
        step(); RST = 0;
        samp(); chk("idle_upd_v", update_valid, 0);

        // ---- single request ----
        step(); drive_req(mk(0, 0, 20'h12345, 10'h3A, 32'hDEADBEEF, 3'd3));
        samp(); chk("t2_ack", REQ_ack, 1);
        step(); REQ_valid = 0; dtlb_req_ready = 1;
        samp(); chk("t2_dtlb_v", dtlb_req_valid, 1); chk("t2_dtlb_vpn", dtlb_req_VPN, 20'h12345);
        step(); dtlb_req_ready = 0; dtlb_resp_valid = 1; dtlb_resp_PPN = 22'h0ABCD;
        samp(); chk("t2_upd_early", update_valid, 0);
        step(); dtlb_resp_valid = 0; update_ready = 1;
        samp();
        chk("t2_upd_v", update_valid, 1);
        chk("t2_ppn", update_PPN, 22'h0ABCD);
        chk("t2_fields", {update_PO_word, update_write_data, update_cq_index, update_byte_mask},
                         {10'h3A, 32'hDEADBEEF, 3'd3, 4'hF});
        chk("t2_exc", {update_exception, update_exception_code}, 0);
        step(); update_ready = 0;
        samp(); chk("t2_upd_done", update_valid, 0);

        // ---- misaligned-exception fast path ----
        step(); drive_req(mk(0, 1, 20'h0F0F0, 10'h1FF, 32'h0BADF00D, 3'd5)); dtlb_req_ready = 1;
        samp();
        step(); REQ_valid = 0;
        samp(); chk("t3_no_dtlb", dtlb_req_valid, 0); chk("t3_upd_early", update_valid, 0);
        step(); update_ready = 1;
        samp();
        chk("t3_upd_v", update_valid, 1); chk("t3_no_dtlb2", dtlb_req_valid, 0);
        chk("t3_exc", {update_exception, update_exception_code}, {1'b1, 4'd6});
        chk("t3_ppn", update_PPN, 0); chk("t3_idx", update_cq_index, 5);
        chk("t3_mis", update_misaligned, 1);
        step(); clr_in();
        samp(); chk("t3_upd_done", update_valid, 0);

        // ---- page + access fault together, MQ target ----
        step(); drive_req(mk(1, 0, 20'hABCDE, 10'h2, 32'h1, 3'd6)); dtlb_req_ready = 1;
        samp();
        step(); REQ_valid = 0;
        samp(); chk("t4_dtlb_v", dtlb_req_valid, 1);
        step(); dtlb_req_ready = 0; dtlb_resp_valid = 1; dtlb_resp_PPN = 22'h3FFFFF;
        dtlb_resp_page_fault = 1; dtlb_resp_access_fault = 1;
        samp();
        step(); clr_in(); update_ready = 1;
        samp();
        chk("t4_upd_v", update_valid, 1); chk("t4_mq", update_is_mq, 1);
        chk("t4_exc", {update_exception, update_exception_code}, {1'b1, 4'd15});
        chk("t4_ppn", update_PPN, 0); chk("t4_idx", update_cq_index, 6);
        step(); clr_in();
        samp();

        // ---- back-to-back with update stall ----
        n_acc = 0;
        for (int i = 0; i < 24; i++) begin
            step();
            if (n_acc < 3) drive_req(mk(0, 0, 20'(32'h100 + n_acc), 10'(n_acc), 32'(n_acc), 3'(n_acc)));
            else REQ_valid = 0;
            dtlb_req_ready = 1; dtlb_resp_valid = 1; dtlb_resp_PPN = 22'h00111;
            update_ready = (i >= 5);
            samp();
            if (i < 6) chk($sformatf("t5_ack%0d", i), REQ_ack, (i < 2));
            cur = {update_valid, update_PPN, update_cq_index, update_write_data};
            if (i == 3) snap = cur;
            if (i == 4) chk("t5_hold", cur, snap);
            if (i == 3) chk("t5_upd_v", update_valid, 1);
            if (REQ_valid && REQ_ack) n_acc++;
            if (update_valid && update_ready) order.push_back(int'(update_cq_index));
        end
        chk("t5_accepted", n_acc, 3);
        chk("t5_nupd", order.size(), 3);
        for (int k = 0; k < 3; k++) chk($sformatf("t5_order%0d", k), (k < order.size()) ? order[k] : -1, k);
        step(); clr_in();
        samp();

        // ---- reset while waiting on the dTLB ----
        step(); drive_req(mk(0, 0, 20'h55555, 10'h5, 32'h5, 3'd7)); dtlb_req_ready = 1;
        samp();
        step(); REQ_valid = 0;
        samp(); chk("t6_dtlb_v", dtlb_req_valid, 1);
        step(); dtlb_req_ready = 0; RST = 1;
        samp();
        chk("t6_rst_dtlb", dtlb_req_valid, 0); chk("t6_rst_upd", update_valid, 0);
        chk("t6_rst_ack", REQ_ack, 1); chk("t6_rst_vpn", dtlb_req_VPN, 0);
        step(); RST = 0; dtlb_resp_valid = 1; dtlb_resp_PPN = 22'h1234;
        samp();
        step(); dtlb_resp_valid = 0; update_ready = 1; dtlb_req_ready = 1;
        for (int i = 0; i < 3; i++) begin
            samp();
            chk("t6_no_upd", update_valid, 0);
            chk("t6_no_dtlb", dtlb_req_valid, 0);
            step();
        end
        clr_in();
        samp();

        // ---- randomized traffic against the reference model ----
        pend = 0; have_x = 0; held = 0; n_upd = 0; dly = 0;
        for (int cyc = 0; cyc < 700; cyc++) begin
            step();
            r.is_mq = 1'($urandom); r.misaligned = 1'($urandom);
            r.misaligned_exception = ($urandom % 4 == 0);
            r.VPN = 20'($urandom); r.PO_word = 10'($urandom); r.byte_mask = 4'($urandom);
            r.write_data = $urandom; r.cq_index = 3'($urandom);
            drive_req(r);
            REQ_valid = (cyc < 600) && ($urandom % 2 == 0);
            dtlb_req_ready = (cyc >= 600) || ($urandom % 2 == 0);
            dtlb_resp_PPN = 22'($urandom);
            dtlb_resp_page_fault = ($urandom % 5 == 0);
            dtlb_resp_access_fault = ($urandom % 5 == 0);
            dtlb_resp_valid = pend ? (dly == 0) : ($urandom % 8 == 0);
            update_ready = (cyc >= 600) || ($urandom % 3 != 0);
            samp();

            chk("r_ack", REQ_ack, (q.size() < 2));
            cur = {update_valid, update_is_mq, update_cq_index, update_PPN, update_PO_word,
                   update_byte_mask, update_misaligned, update_exception, update_exception_code};
            if (update_valid) begin
                if (q.size() == 0) chk("r_upd_spur", 1, 0);
                else begin
                    e = q[0];
                    chk("r_upd_fields",
                        {update_is_mq, update_cq_index, update_PO_word, update_byte_mask, update_misaligned, update_write_data},
                        {e.is_mq, e.cq_index, e.PO_word, e.byte_mask, e.misaligned, e.write_data});
                    if (e.misaligned_exception)
                        chk("r_upd_mx", {update_exception, update_exception_code, update_PPN}, {1'b1, 4'd6, 22'h0});
                    else begin
                        chk("r_upd_xlated", have_x, 1);
                        chk("r_upd_res", {update_exception, update_exception_code, update_PPN}, {x_exc, x_code, x_ppn});
                    end
                end
                if (held) chk("r_upd_hold", cur, snap);
            end
            held = update_valid && !update_ready;
            snap = cur;
            if (update_valid && update_ready && q.size() > 0) begin
                void'(q.pop_front()); have_x = 0; n_upd++;
            end

            if (pend && dtlb_resp_valid) begin
                x_exc  = dtlb_resp_page_fault | dtlb_resp_access_fault;
                x_code = dtlb_resp_page_fault ? 4'd15 : (dtlb_resp_access_fault ? 4'd7 : 4'd0);
                x_ppn  = x_exc ? 22'h0 : dtlb_resp_PPN;
                pend = 0; have_x = 1;
            end else if (pend && dly > 0) dly--;

            if (dtlb_req_valid) begin
                if (q.size() == 0) chk("r_dtlb_spur", 1, 0);
                else begin
                    chk("r_dtlb_vpn", dtlb_req_VPN, q[0].VPN);
                    chk("r_dtlb_mx", q[0].misaligned_exception, 0);
                end
                if (dtlb_req_ready) begin
                    chk("r_dtlb_one", {pend, have_x}, 0);
                    pend = 1; dly = $urandom % 3;
                end
            end

            if (REQ_valid && REQ_ack) q.push_back(r);
        end
        chk("r_drained", q.size(), 0);
        chk("r_some_upd", (n_upd > 20), 1);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

// File: doc/stamofu_req_tlb_stage.md
Name: stamofu_req_tlb_stage

Overview:
- Consumer end of the stamofu address pipeline REQ interface.
- Accepts translated-pending store/AMO/fence requests (VPN, PO_word, byte_mask, write_data, cq_index) into a small FIFO and translates each head entry through the dTLB, one at a time.
- Reports the physical address, or the exception, to the stamofu CQ, or to the misaligned queue (MQ) when the request is flagged is_mq.

Parameters:
- FIFO_DEPTH, 2, REQ buffer entries (power of 2, >=2).
- LOG_FIFO_DEPTH, $clog2(FIFO_DEPTH), pointer width without wrap bit.

Ports:
- CLK  in  1  clock
- RST  in  1  asynchronous active-high reset
- REQ_valid  in  1  request present
- REQ_is_mq  in  1  result goes to MQ, not CQ
- REQ_misaligned  in  1  access crosses a word
- REQ_misaligned_exception  in  1  misaligned access is illegal
- REQ_VPN  in  VPN_WIDTH(20)  virtual page number
- REQ_PO_word  in  PO_WIDTH-2(10)  page-offset word
- REQ_byte_mask  in  4  byte enables
- REQ_write_data  in  32  store data
- REQ_cq_index  in  LOG_STAMOFU_CQ_ENTRIES  CQ/MQ slot
- REQ_ack  out  1  request accepted this cycle
- dtlb_req_valid  out  1  translation request
- dtlb_req_VPN  out  20  VPN to translate
- dtlb_req_ready  in  1  dTLB accepts request
- dtlb_resp_valid  in  1  translation complete
- dtlb_resp_PPN  in  PPN_WIDTH(22)  physical page
- dtlb_resp_page_fault  in  1  store page fault
- dtlb_resp_access_fault  in  1  store access fault
- update_valid  out  1  result to CQ/MQ
- update_is_mq  out  1  target is MQ
- update_cq_index  out  LOG_STAMOFU_CQ_ENTRIES  slot
- update_PPN  out  22  translated page (0 on exception)
- update_PO_word  out  10  passthrough
- update_byte_mask  out  4  passthrough
- update_misaligned  out  1  passthrough
- update_write_data  out  32  passthrough
- update_exception  out  1  exception flag
- update_exception_code  out  4  RISC-V cause
- update_ready  in  1  CQ/MQ accepts update

Behaviour:
- Reset (async, RST=1): FIFO empty (head/tail/count 0), FSM=IDLE.
- Outputs during reset: REQ_ack=1, dtlb_req_valid=0, update_valid=0, all update_* data outputs and dtlb_req_VPN = 0.
- FIFO:
  - REQ_ack = !full, combinational.
  - Enqueue when REQ_valid & REQ_ack.
  - Dequeue when update_valid & update_ready.
  - Simultaneous enqueue and dequeue when full is NOT allowed: REQ_ack depends only on registered count.
  - Pointers wrap modulo FIFO_DEPTH.
- FSM on head entry:
  - IDLE: if FIFO non-empty, go to TLB_REQ. If the head has REQ_misaligned_exception, go to UPDATE with exception=1, code=6 (store misaligned).
  - TLB_REQ: dtlb_req_valid=1, dtlb_req_VPN=head VPN. On dtlb_req_ready, go to TLB_WAIT.
  - TLB_WAIT: on dtlb_resp_valid, latch PPN/faults into head-result registers and go to UPDATE.
    - page_fault: exception=1, code=15. It takes priority over access_fault.
    - access_fault: exception=1, code=7.
    - Otherwise exception=0, code=0.
    - dtlb_resp_valid in any other state is ignored.
  - UPDATE: update_valid=1 with head fields and latched result. On update_ready: pop, then go to TLB_REQ if another entry remains (same exception check as IDLE), else IDLE.
- Latency:
  - Enqueue into empty FIFO: dtlb_req_valid the next cycle.
  - dtlb_resp in cycle N: update_valid in cycle N+1.
  - Best-case REQ-to-update is 3 cycles with a 0-cycle dTLB.
  - Fast path: a misaligned-exception entry reaches update 2 cycles after enqueue.
- Exceptions: update_PPN=0. Other fields pass through unchanged.
- Only one dTLB translation is outstanding at a time. dtlb_req_valid stays high until ready, and dtlb_req_VPN is stable while it is high.
- update_* outputs are stable while update_valid=1 and update_ready=0.
- Fence entries are normal entries; the upstream pipeline supplies their VPN/mask.
- Reset mid-operation: all state drops immediately. No update or dTLB request is emitted after RST rises.

Decomposition:
- Package core_types_pkg: VPN_WIDTH, PPN_WIDTH, PO_WIDTH, LOG_STAMOFU_CQ_ENTRIES.
- Package core_types_pkg, new additions:
  - typedef stamofu_req_entry_t (is_mq, misaligned, misaligned_exception, VPN, PO_word, byte_mask, write_data, cq_index).
  - Localparams for exception codes: STORE_MISALIGNED=6, STORE_ACCESS_FAULT=7, STORE_PAGE_FAULT=15.
- Sub-module: stamofu_req_fifo, parameterized FIFO of stamofu_req_entry_t with full/empty. The FSM stays in the top.

Test Plan:
- Reset, then idle: REQ_ack=1, dtlb_req_valid=0, update_valid=0, all data outputs 0.
- Single request VPN=20'h12345, PO_word=10'h3A, mask=4'b1111, data=32'hDEADBEEF, cq_index=3; dtlb_req_ready=1; resp one cycle later with PPN=22'h0ABCD -> update_valid with PPN 0ABCD, PO 3A, data DEADBEEF, index 3, exception=0.
- Misaligned exception entry (cq_index=5) -> no dtlb_req_valid; update 2 cycles after enqueue with exception=1, code=6, PPN=0.
- dTLB page_fault=1 and access_fault=1 together on is_mq=1 entry -> update_is_mq=1, exception=1, code=15.
- Three back-to-back REQs, update_ready=0 for 5 cycles -> REQ_ack falls after 2 accepts; outputs held stable; release -> updates in order 0,1,2 and third REQ accepted when count drops.
- RST asserted while in TLB_WAIT -> outputs to reset values same cycle; late dtlb_resp_valid ignored; no update emitted.
